simt_branch_unit: RTL and testbench

//   Multi-lane successor of the single-thread NZP/BEN logic. Holds per-lane condition

---
 rtl/simt_branch_unit.sv | 136 +++++++++++++
 tb/tb_simt_branch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/simt_branch_unit.sv
// SIMT branch unit: per-lane NZP condition codes, per-lane LC-3 branch evaluation,
// and a {mask, PC} reconvergence stack for divergent branches.
module simt_branch_unit #(
  parameter int LANES       = 4,
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   LD_CC,
  input  logic                   LD_BEN,
  input  logic [LANES*WIDTH-1:0] bus,
  input  logic [15:0]            IR,
  input  logic                   BR_EVAL,
  input  logic [15:0]            PC_FALL,
  input  logic                   SYNC,
  output logic                   BEN,
  output logic [LANES-1:0]       active_mask,
  output logic                   DIVERGE,
  output logic                   resume_valid,
  output logic [15:0]            resume_pc,
  output logic                   stack_empty,
  output logic                   stack_full,
  output logic                   stack_err
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH);

  logic [2:0]       nzp_q [LANES];
  logic [2:0]       nzp_d [LANES];
  logic [LANES-1:0] ben_q, ben_d;
  logic [LANES-1:0] act_q, act_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             div_q, div_d;
  logic             rv_q, rv_d;
  logic [15:0]      rpc_q, rpc_d;
  logic             err_q, err_d;
  logic             push;
  logic [LANES-1:0] taken;
  logic [SPW-1:0]   top_idx;

  // One spare slot so the array index width matches the stack pointer width.
  logic [LANES-1:0] stk_mask_q [STACK_DEPTH+1];
  logic [15:0]      stk_pc_q   [STACK_DEPTH+1];

  logic unused_ir;
  assign unused_ir = ^{IR[15:12], IR[8:0]};

  function automatic logic [2:0] nzp_of(input logic signed [WIDTH-1:0] v);
    logic n, z;
    n = v[WIDTH-1];
    z = (v == '0);
    return {n, z, ~n & ~z};
  endfunction

  assign taken   = ben_q & act_q;
  assign top_idx = sp_q - SPW'(1);

  always_comb begin
    nzp_d = nzp_q;
    ben_d = ben_q;
    act_d = act_q;
    sp_d  = sp_q;
    div_d = 1'b0;
    rv_d  = 1'b0;
    rpc_d = rpc_q;
    err_d = err_q;
    push  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (LD_CC && act_q[i]) nzp_d[i] = nzp_of(bus[i*WIDTH +: WIDTH]);
      if (LD_BEN) ben_d[i] = act_q[i] & |(nzp_q[i] & IR[11:9]);
    end
    // BR_EVAL has priority; a simultaneous SYNC is dropped silently.
    if (BR_EVAL) begin
      if (taken != '0 && taken != act_q) begin
        if (sp_q == SP_MAX) begin
          err_d = 1'b1;
        end else begin
          push  = 1'b1;
          sp_d  = sp_q + SPW'(1);
          act_d = taken;
          div_d = 1'b1;
        end
      end
    end else if (SYNC) begin
      if (sp_q == '0) begin
        err_d = 1'b1;
      end else begin
        sp_d  = top_idx;
        act_d = stk_mask_q[top_idx];
        rpc_d = stk_pc_q[top_idx];
        rv_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LANES; i++) nzp_q[i] <= 3'b010;
      ben_q <= '0;
      act_q <= '1;
      sp_q  <= '0;
      div_q <= 1'b0;
      rv_q  <= 1'b0;
      rpc_q <= '0;
      err_q <= 1'b0;
    end else begin
      nzp_q <= nzp_d;
      ben_q <= ben_d;
      act_q <= act_d;
      sp_q  <= sp_d;
      div_q <= div_d;
      rv_q  <= rv_d;
      rpc_q <= rpc_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && push) begin
      stk_mask_q[sp_q] <= act_q & ~taken;
      stk_pc_q[sp_q]   <= PC_FALL;
    end
  end

  assign BEN          = |(ben_q & act_q);
  assign active_mask  = act_q;
  assign DIVERGE      = div_q;
  assign resume_valid = rv_q;
  assign resume_pc    = rpc_q;
  assign stack_empty  = (sp_q == '0);
  assign stack_full   = (sp_q == SP_MAX);
  assign stack_err    = err_q;

endmodule

// File: tb/tb_simt_branch_unit.sv
// Bench for simt_branch_unit: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_simt_branch_unit;

  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;  // small depth so 4 lanes can nest past full

  logic                   Clk = 1'b0;
  logic                   Reset, LD_CC, LD_BEN, BR_EVAL, SYNC;
  logic [LANES*WIDTH-1:0] bus;
  logic [15:0]            IR, PC_FALL;
  logic                   BEN, DIVERGE, resume_valid, stack_empty, stack_full, stack_err;
  logic [LANES-1:0]       active_mask;
  logic [15:0]            resume_pc;

  simt_branch_unit #(.LANES(LANES), .WIDTH(WIDTH), .STACK_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .bus(bus), .IR(IR),
    .BR_EVAL(BR_EVAL), .PC_FALL(PC_FALL), .SYNC(SYNC), .BEN(BEN),
    .active_mask(active_mask), .DIVERGE(DIVERGE), .resume_valid(resume_valid),
    .resume_pc(resume_pc), .stack_empty(stack_empty), .stack_full(stack_full),
    .stack_err(stack_err)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct { logic [LANES-1:0] mask; logic [15:0] pc; } entry_t;
  entry_t           m_stk[$];
  int               m_cc  [LANES];   // 4 = N, 2 = Z, 1 = P
  logic [LANES-1:0] m_act, m_ben;
  logic             m_div, m_rv, m_err;
  logic [15:0]      m_rpc;

  function automatic int cc_of(input logic [WIDTH-1:0] v);
    if ($signed(v) < 0) return 4;
    if (v == 0) return 2;
    return 1;
  endfunction

  always @(posedge Clk) begin
    int               old_cc [LANES];
    logic [LANES-1:0] old_act, old_ben, t;
    entry_t           e;
    if (Reset) begin
      for (int i = 0; i < LANES; i++) m_cc[i] = 2;
      m_ben = '0; m_act = '1; m_stk.delete();
      m_div = 0; m_rv = 0; m_rpc = '0; m_err = 0;
    end else begin
      old_cc = m_cc; old_act = m_act; old_ben = m_ben;
      m_div = 0; m_rv = 0;
      for (int i = 0; i < LANES; i++) begin
        if (LD_CC && old_act[i]) m_cc[i] = cc_of(bus[i*WIDTH +: WIDTH]);
        if (LD_BEN) m_ben[i] = old_act[i] && ((old_cc[i] & int'(IR[11:9])) != 0);
      end
      if (BR_EVAL) begin
        t = old_ben & old_act;
        if (t != 0 && t != old_act) begin
          if (m_stk.size() < DEPTH) begin
            e.mask = old_act & ~t; e.pc = PC_FALL;
            m_stk.push_back(e);
            m_act = t; m_div = 1;
          end else m_err = 1;
        end
      end else if (SYNC) begin
        if (m_stk.size() > 0) begin
          e = m_stk.pop_back();
          m_act = e.mask; m_rpc = e.pc; m_rv = 1;
        end else m_err = 1;
      end
    end
    #1;
    chk("BEN",          BEN,          |(m_ben & m_act));
    chk("active_mask",  active_mask,  m_act);
    chk("DIVERGE",      DIVERGE,      m_div);
    chk("resume_valid", resume_valid, m_rv);
    chk("resume_pc",    resume_pc,    m_rpc);
    chk("stack_empty",  stack_empty,  m_stk.size() == 0);
    chk("stack_full",   stack_full,   m_stk.size() == DEPTH);
    chk("stack_err",    stack_err,    m_err);
  end

  // Directed stimulus
  task automatic step(input logic cc, input logic bn, input logic br, input logic sy,
                      input logic [2:0] cond, input logic [63:0] b, input logic [15:0] pcf);
    LD_CC = cc; LD_BEN = bn; BR_EVAL = br; SYNC = sy;
    IR = {4'h0, cond, 9'h000}; bus = b; PC_FALL = pcf;
    @(negedge Clk);
    LD_CC = 0; LD_BEN = 0; BR_EVAL = 0; SYNC = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 3'b000, '0, '0);
  endtask

  task automatic do_reset();
    Reset = 1;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 0;
  endtask

  localparam logic [63:0] V = {16'h8000, 16'h0000, 16'h0005, 16'h7FFF};

  initial begin
    Reset = 1; LD_CC = 0; LD_BEN = 0; BR_EVAL = 0; SYNC = 0;
    bus = '0; IR = '0; PC_FALL = '0;
    @(negedge Clk);
    do_reset();
    chk("rst active", active_mask, 4'hF);
    chk("rst empty",  stack_empty, 1);
    chk("rst err",    stack_err,   0);
    chk("rst BEN",    BEN,         0);

    step(0, 1, 0, 0, 3'b010, '0, '0);
    chk("Z ben", BEN, 1);

    step(1, 0, 0, 0, 3'b000, V, '0);
    step(0, 1, 0, 0, 3'b001, V, '0);
    chk("P ben", BEN, 1);

    step(0, 0, 1, 0, 3'b000, V, 16'h3010);
    chk("div pulse",  DIVERGE,     1);
    chk("div active", active_mask, 4'b0011);
    chk("div sp1",    stack_empty, 0);
    idle();
    chk("div drop",   DIVERGE,     0);
    step(0, 0, 0, 1, 3'b000, '0, '0);
    chk("pop rv",     resume_valid, 1);
    chk("pop pc",     resume_pc,    16'h3010);
    chk("pop active", active_mask,  4'b1100);
    chk("pop empty",  stack_empty,  1);

    step(0, 0, 0, 1, 3'b000, '0, '0);
    chk("underflow err",    stack_err,    1);
    chk("underflow active", active_mask,  4'b1100);
    chk("underflow rv",     resume_valid, 0);

    // Nested divergence past a full stack, then reset mid-divergence
    do_reset();
    step(1, 0, 0, 0, 3'b000, V, '0);
    step(0, 1, 0, 0, 3'b011, V, '0);
    step(0, 0, 1, 0, 3'b000, V, 16'h4000);
    chk("nest1 active", active_mask, 4'b0111);
    step(0, 1, 0, 0, 3'b001, V, '0);
    step(0, 0, 1, 0, 3'b000, V, 16'h4100);
    chk("nest2 active", active_mask, 4'b0011);
    chk("nest2 full",   stack_full,  1);
    step(1, 0, 0, 0, 3'b000, {16'h0, 16'h0, 16'h0005, 16'h0000}, '0);
    step(0, 1, 0, 0, 3'b001, '0, '0);
    step(0, 0, 1, 0, 3'b000, '0, 16'h4200);
    chk("ovf div",    DIVERGE,     0);
    chk("ovf active", active_mask, 4'b0011);
    chk("ovf err",    stack_err,   1);
    do_reset();
    chk("midrst active", active_mask, 4'hF);
    chk("midrst empty",  stack_empty, 1);
    chk("midrst err",    stack_err,   0);

    // BR_EVAL + SYNC together, inactive-lane LD_CC, LIFO pops
    step(1, 0, 0, 0, 3'b000, {16'h0, 16'h0, 16'h0005, 16'h0007}, '0);
    step(0, 1, 0, 0, 3'b001, '0, '0);
    step(0, 0, 1, 1, 3'b000, '0, 16'h5000);
    chk("both div",    DIVERGE,      1);
    chk("both rv",     resume_valid, 0);
    chk("both active", active_mask,  4'b0011);
    chk("both err",    stack_err,    0);
    step(1, 0, 0, 0, 3'b000, {16'h8000, 16'h0, 16'h0, 16'h0009}, '0);
    step(0, 1, 0, 0, 3'b001, '0, '0);
    step(0, 0, 1, 0, 3'b000, '0, 16'h5100);
    chk("push2 full", stack_full, 1);
    step(0, 0, 0, 1, 3'b000, '0, '0);
    chk("lifo pc1",  resume_pc,   16'h5100);
    chk("lifo act1", active_mask, 4'b0010);
    step(0, 0, 0, 1, 3'b000, '0, '0);
    chk("lifo pc2",  resume_pc,   16'h5000);
    chk("lifo act2", active_mask, 4'b1100);
    step(0, 1, 0, 0, 3'b100, '0, '0);
    chk("inactive lane kept Z", BEN, 0);
    step(0, 0, 1, 0, 3'b000, '0, 16'h6000);
    chk("uniform no div", DIVERGE, 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
